// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_e      - clear-sequencer state (CLEAR, RUN)
//   lane_count   - number of byte lanes in a word (usable in localparams)
//   merge_lanes  - byte-lane merge shared by the write path and the
//                  write-first read bypass
package data_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Widest word the lane-merge helper handles; callers cast in and out.
  localparam int MAX_DW    = 512;
  localparam int MAX_LANES = MAX_DW / 8;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  // Lane k of the result comes from new_w when mask[k] is set, else old_w.
  function automatic logic [MAX_DW-1:0] merge_lanes(
    input logic [MAX_DW-1:0]    old_w,
    input logic [MAX_DW-1:0]    new_w,
    input logic [MAX_LANES-1:0] mask
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (mask[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_clear_sequencer.sv
// Post-reset clear sequencer: walks every word once, writing zero or a preset.
// Latency: exactly MEM_SIZE cycles from the first edge after reset release.
// Backpressure: none; runs unconditionally and owns the array write port.
//
// Ports:
//   clock, reset      - clock and asynchronous active-low reset
//   clr_we            - array write strobe while clearing
//   clr_addr/clr_data - word index and value for the current clear write
//   ready             - registered, high once the last word has been written
module mem_clear_sequencer
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_LINE = 8,
  parameter int MEM_SIZE     = 256,
  parameter int INIT_ADDR0   = 1,
  parameter int INIT_VAL0    = 5,
  parameter int INIT_ADDR1   = 2,
  parameter int INIT_VAL1    = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    clr_we,
  output logic [ADDRESS_LINE-1:0] clr_addr,
  output logic [DATA_WIDTH-1:0]   clr_data,
  output logic                    ready
);

  localparam logic [ADDRESS_LINE-1:0] CNT_LAST = ADDRESS_LINE'(MEM_SIZE - 1);
  localparam logic [ADDRESS_LINE-1:0] CNT_ONE  = ADDRESS_LINE'(1);
  localparam logic [ADDRESS_LINE-1:0] PRE_A0   = ADDRESS_LINE'(INIT_ADDR0);
  localparam logic [ADDRESS_LINE-1:0] PRE_A1   = ADDRESS_LINE'(INIT_ADDR1);
  localparam logic [DATA_WIDTH-1:0]   PRE_V0   = DATA_WIDTH'(INIT_VAL0);
  localparam logic [DATA_WIDTH-1:0]   PRE_V1   = DATA_WIDTH'(INIT_VAL1);

  state_e                  state_q;
  logic [ADDRESS_LINE-1:0] clear_count_q;
  logic                    ready_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= CLEAR;
      clear_count_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          // The write of the last index happens on this same edge.
          if (clear_count_q == CNT_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            clear_count_q <= clear_count_q + CNT_ONE;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = clear_count_q;
  assign ready    = ready_q;

  always_comb begin
    clr_data = '0;
    if (clear_count_q == PRE_A0) begin
      clr_data = PRE_V0;
    end else if (clear_count_q == PRE_A1) begin
      clr_data = PRE_V1;
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory with byte-lane write mask and write-first read bypass.
// Latency: reads return one cycle after the accepting edge; writes commit at it.
// Backpressure: stall is high (combinational) for any request until ready.
//
// Ports:
//   clock, reset                 - clock and asynchronous active-low reset
//   mem_read, mem_write, address - request; accepted when ready
//   write_data, byte_enable      - write word and per-byte-lane mask
//   read_data, read_valid        - registered read result and its qualifier
//   addr_error                   - registered pulse for an out-of-range access
//   stall, ready                 - request blocked / clear sequence complete
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_LINE = 8,
  parameter int MEM_SIZE     = 256,
  parameter int INIT_ADDR0   = 1,
  parameter int INIT_VAL0    = 5,
  parameter int INIT_ADDR1   = 2,
  parameter int INIT_VAL1    = 6
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                mem_read,
  input  logic                                mem_write,
  input  logic [ADDRESS_LINE-1:0]             address,
  input  logic [DATA_WIDTH-1:0]               write_data,
  input  logic [lane_count(DATA_WIDTH)-1:0]   byte_enable,
  output logic [DATA_WIDTH-1:0]               read_data,
  output logic                                read_valid,
  output logic                                addr_error,
  output logic                                stall,
  output logic                                ready
);

  // One extra bit so MEM_SIZE == 2**ADDRESS_LINE compares correctly.
  localparam logic [ADDRESS_LINE:0] SIZE_W = (ADDRESS_LINE + 1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  logic                    clr_we;
  logic [ADDRESS_LINE-1:0] clr_addr;
  logic [DATA_WIDTH-1:0]   clr_data;
  logic                    seq_ready;

  mem_clear_sequencer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_LINE (ADDRESS_LINE),
    .MEM_SIZE     (MEM_SIZE),
    .INIT_ADDR0   (INIT_ADDR0),
    .INIT_VAL0    (INIT_VAL0),
    .INIT_ADDR1   (INIT_ADDR1),
    .INIT_VAL1    (INIT_VAL1)
  ) u_clear (
    .clock    (clock),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data),
    .ready    (seq_ready)
  );

  logic                    req_any;
  logic                    accept;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    req_we;
  logic                    arr_we;
  logic [ADDRESS_LINE-1:0] arr_idx;
  logic [DATA_WIDTH-1:0]   arr_dat;

  logic [DATA_WIDTH-1:0]   read_data_d, read_data_q;
  logic                    read_valid_d, read_valid_q;
  logic                    addr_error_d, addr_error_q;

  assign req_any  = mem_read | mem_write;
  assign accept   = seq_ready & req_any;
  assign in_range = ({1'b0, address} < SIZE_W);

  // old_word is only consumed when in_range, so an out-of-range index is benign.
  assign old_word    = mem_q[address];
  assign merged_word = DATA_WIDTH'(merge_lanes(MAX_DW'(old_word),
                                               MAX_DW'(write_data),
                                               MAX_LANES'(byte_enable)));

  assign req_we = accept & mem_write & in_range;

  // Single array write port: the clear sequencer owns it until ready, and
  // requests are never accepted before ready, so the two never collide.
  always_comb begin
    arr_we  = clr_we | req_we;
    arr_idx = address;
    arr_dat = merged_word;
    if (clr_we) begin
      arr_idx = clr_addr;
      arr_dat = clr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (arr_we) begin
      mem_q[arr_idx] <= arr_dat;
    end
  end

  always_comb begin
    read_data_d  = '0;
    read_valid_d = accept & mem_read;
    addr_error_d = accept & ~in_range;
    if (accept && mem_read && in_range) begin
      // Write-first: a same-cycle write shows its enabled lanes on the read.
      read_data_d = mem_write ? merged_word : old_word;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_error = addr_error_q;
  assign stall      = ~seq_ready & req_any;
  assign ready      = seq_ready;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  localparam int DW = 32;
  localparam int AL = 8;
  localparam int MS = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AL-1:0] address = '0;
  logic [DW-1:0] write_data = '0;
  logic [3:0]    byte_enable = '0;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          addr_error;
  logic          stall;
  logic          ready;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [MS];

  data_memory_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDRESS_LINE (AL),
    .MEM_SIZE     (MS),
    .INIT_ADDR0   (1),
    .INIT_VAL0    (5),
    .INIT_ADDR1   (2),
    .INIT_VAL1    (6)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .byte_enable (byte_enable),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .addr_error  (addr_error),
    .stall       (stall),
    .ready       (ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents expected right after a completed clear pass.
  function automatic void model_init();
    for (int i = 0; i < MS; i++) model[i] = '0;
    model[1] = 32'd5;
    model[2] = 32'd6;
  endfunction

  // Reference behaviour of one accepted request, from the access rules.
  function automatic void model_step(input logic rd, input logic wr,
                                     input logic [AL-1:0] a, input logic [DW-1:0] wd,
                                     input logic [3:0] be,
                                     output logic [DW-1:0] ed, output logic ev,
                                     output logic ee);
    logic [DW-1:0] m;
    logic [DW-1:0] nw;
    ed = '0;
    ev = rd;
    ee = (rd || wr) && (int'(a) >= MS);
    if (int'(a) < MS) begin
      for (int k = 0; k < 4; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
      nw = (wd & m) | (model[a] & ~m);
      if (rd) ed = wr ? nw : model[a];
      if (wr) model[a] = nw;
    end
  endfunction

  // Drive one request and advance to just after the next rising edge.
  task automatic cyc(input logic rd, input logic wr, input logic [AL-1:0] a,
                     input logic [DW-1:0] wd, input logic [3:0] be);
    mem_read    = rd;
    mem_write   = wr;
    address     = a;
    write_data  = wd;
    byte_enable = be;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    mem_read = 1'b1;
    address  = 8'd1;
    @(posedge clock);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", stall); end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++;
    if ({read_valid, addr_error, read_data} !== {2'b00, 32'h0})
      begin bad++; $display("FAIL reset_outputs got=%b%b_%h exp=00_00000000", read_valid, addr_error, read_data); end
  endtask

  task automatic test_clear();
    logic [DW-1:0] ed;
    logic ev, ee;
    mem_read = 1'b1;
    address  = 8'd1;
    reset    = 1'b1;
    for (int i = 1; i <= MS; i++) begin
      total++;
      if ({stall, ready, read_valid} !== 3'b100)
        begin bad++; $display("FAIL clear_stall cycle=%0d got=%b exp=100", i, {stall, ready, read_valid}); end
      @(posedge clock);
      #1;
    end
    total++;
    if ({ready, stall, read_valid} !== 3'b100)
      begin bad++; $display("FAIL clear_done got=%b exp=100", {ready, stall, read_valid}); end
    model_init();
    for (int a = 1; a <= 3; a++) begin
      model_step(1'b1, 1'b0, AL'(a), '0, 4'h0, ed, ev, ee);
      cyc(1'b1, 1'b0, AL'(a), '0, 4'h0);
      total++;
      if ({read_valid, addr_error, read_data} !== {ev, ee, ed})
        begin bad++; $display("FAIL preset_read addr=%0d got=%b%b_%h exp=%b%b_%h", a, read_valid, addr_error, read_data, ev, ee, ed); end
    end
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] ed;
    logic ev, ee;
    model_step(1'b0, 1'b1, 8'd10, 32'hAABBCCDD, 4'hF, ed, ev, ee);
    cyc(1'b0, 1'b1, 8'd10, 32'hAABBCCDD, 4'hF);
    total++;
    if ({read_valid, addr_error, read_data} !== {2'b00, 32'h0})
      begin bad++; $display("FAIL write_only_out got=%b%b_%h exp=00_00000000", read_valid, addr_error, read_data); end
    model_step(1'b0, 1'b1, 8'd10, 32'h11223344, 4'b0101, ed, ev, ee);
    cyc(1'b0, 1'b1, 8'd10, 32'h11223344, 4'b0101);
    model_step(1'b1, 1'b0, 8'd10, '0, 4'h0, ed, ev, ee);
    cyc(1'b1, 1'b0, 8'd10, '0, 4'h0);
    total++;
    if ({read_valid, read_data} !== {1'b1, 32'hAA22CC44})
      begin bad++; $display("FAIL byte_mask got=%b_%h exp=1_aa22cc44", read_valid, read_data); end
    // All-zero mask leaves the word alone.
    model_step(1'b0, 1'b1, 8'd10, 32'h55555555, 4'h0, ed, ev, ee);
    cyc(1'b0, 1'b1, 8'd10, 32'h55555555, 4'h0);
    cyc(1'b1, 1'b0, 8'd10, '0, 4'h0);
    total++;
    if (read_data !== 32'hAA22CC44)
      begin bad++; $display("FAIL zero_mask got=%h exp=aa22cc44", read_data); end
  endtask

  task automatic test_write_first();
    logic [DW-1:0] ed;
    logic ev, ee;
    model_step(1'b1, 1'b1, 8'd5, 32'hFFFFFFFF, 4'b0011, ed, ev, ee);
    cyc(1'b1, 1'b1, 8'd5, 32'hFFFFFFFF, 4'b0011);
    total++;
    if ({read_valid, read_data} !== {1'b1, 32'h0000FFFF})
      begin bad++; $display("FAIL write_first got=%b_%h exp=1_0000ffff", read_valid, read_data); end
    cyc(1'b1, 1'b0, 8'd5, '0, 4'h0);
    total++;
    if ({read_valid, read_data} !== {1'b1, 32'h0000FFFF})
      begin bad++; $display("FAIL write_first_reread got=%b_%h exp=1_0000ffff", read_valid, read_data); end
  endtask

  task automatic test_idle();
    cyc(1'b1, 1'b0, 8'd2, '0, 4'h0);
    cyc(1'b0, 1'b0, 8'd2, '0, 4'h0);
    total++;
    if ({read_valid, addr_error, stall, read_data} !== {3'b000, 32'h0})
      begin bad++; $display("FAIL idle got=%b%b%b_%h exp=000_00000000", read_valid, addr_error, stall, read_data); end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] ed;
    logic ev, ee;
    cyc(1'b1, 1'b0, 8'd250, '0, 4'h0);
    total++;
    if ({read_valid, addr_error, read_data} !== {2'b11, 32'h0})
      begin bad++; $display("FAIL oor_read got=%b%b_%h exp=11_00000000", read_valid, addr_error, read_data); end
    cyc(1'b0, 1'b1, 8'd250, 32'hDEADBEEF, 4'hF);
    total++;
    if ({read_valid, addr_error} !== 2'b01)
      begin bad++; $display("FAIL oor_write got=%b%b exp=01", read_valid, addr_error); end
    cyc(1'b1, 1'b0, 8'd200, '0, 4'h0);
    total++;
    if ({read_valid, addr_error} !== 2'b11)
      begin bad++; $display("FAIL oor_edge200 got=%b%b exp=11", read_valid, addr_error); end
    for (int a = 0; a < MS; a++) begin
      model_step(1'b1, 1'b0, AL'(a), '0, 4'h0, ed, ev, ee);
      cyc(1'b1, 1'b0, AL'(a), '0, 4'h0);
      total++;
      if ({read_valid, addr_error, read_data} !== {ev, ee, ed})
        begin bad++; $display("FAIL sweep addr=%0d got=%b%b_%h exp=%b%b_%h", a, read_valid, addr_error, read_data, ev, ee, ed); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic ev, ee;
    logic rd, wr;
    logic [AL-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0] be;
    for (int n = 0; n < 400; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      // Bias towards a small in-range window so writes get read back.
      a  = (n % 4 == 0) ? AL'($urandom_range(0, 255)) : AL'($urandom_range(0, 15));
      wd = $urandom;
      be = 4'($urandom);
      model_step(rd, wr, a, wd, be, ed, ev, ee);
      cyc(rd, wr, a, wd, be);
      total++;
      if ({read_valid, addr_error, read_data} !== {ev, ee, ed})
        begin bad++; $display("FAIL random n=%0d addr=%0d rd=%b wr=%b got=%b%b_%h exp=%b%b_%h", n, a, rd, wr, read_valid, addr_error, read_data, ev, ee, ed); end
    end
  endtask

  task automatic test_reset_midclear();
    cyc(1'b0, 1'b1, 8'd3, 32'h00000077, 4'hF);
    cyc(1'b1, 1'b0, 8'd3, '0, 4'h0);
    total++;
    if ({read_valid, read_data} !== {1'b1, 32'h77})
      begin bad++; $display("FAIL pre_reset_write got=%b_%h exp=1_00000077", read_valid, read_data); end
    // Asynchronous reset clears the registered outputs between edges.
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({read_valid, ready, read_data} !== {2'b00, 32'h0})
      begin bad++; $display("FAIL async_reset got=%b%b_%h exp=00_00000000", read_valid, ready, read_data); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    #1;
    total++;
    if ({ready, stall} !== 2'b01)
      begin bad++; $display("FAIL midclear_reset got=%b exp=01", {ready, stall}); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= MS; i++) begin
      @(posedge clock);
      #1;
      total++;
      if (ready !== (i == MS))
        begin bad++; $display("FAIL restart_ready edge=%0d got=%b exp=%b", i, ready, (i == MS)); end
    end
    model_init();
    cyc(1'b1, 1'b0, 8'd3, '0, 4'h0);
    total++;
    if ({read_valid, read_data} !== {1'b1, model[3]})
      begin bad++; $display("FAIL cleared_addr3 got=%b_%h exp=1_%h", read_valid, read_data, model[3]); end
    cyc(1'b1, 1'b0, 8'd1, '0, 4'h0);
    total++;
    if ({read_valid, read_data} !== {1'b1, 32'd5})
      begin bad++; $display("FAIL restored_addr1 got=%b_%h exp=1_00000005", read_valid, read_data); end
  endtask

  initial begin
    #3;
    test_reset();
    test_clear();
    test_byte_lanes();
    test_write_first();
    test_idle();
    test_out_of_range();
    test_random();
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the pipeline's MEM stage. It supports configurable data width, depth and byte-lane write masking, and returns reads through a registered one-cycle port. After reset it runs a self-clear sequence that zeroes the array and loads two preset words, holding `stall` high to the pipeline until the array is usable. It replaces the fixed 8-bit, 256-entry data memory.

## Interface
Parameters:
- DATA_WIDTH, 8 — word width in bits; must be a multiple of 8.
- ADDRESS_LINE, 8 — address width.
- MEM_SIZE, 256 — number of words; must be ≤ 2^ADDRESS_LINE.
- INIT_ADDR0, 1 — address of the first preset word.
- INIT_VAL0, 5 — value of the first preset word.
- INIT_ADDR1, 2 — address of the second preset word.
- INIT_VAL1, 6 — value of the second preset word.

Ports:
- clock  in  1  — single clock; all logic on the rising edge.
- reset  in  1  — asynchronous, active-low reset.
- mem_read  in  1  — read request.
- mem_write  in  1  — write request.
- address  in  ADDRESS_LINE  — word address.
- write_data  in  DATA_WIDTH  — write data.
- byte_enable  in  DATA_WIDTH/8  — per-lane write mask; bit k covers bits [8k+7:8k].
- read_data  out  DATA_WIDTH  — registered read result.
- read_valid  out  1  — one-cycle pulse qualifying read_data.
- addr_error  out  1  — one-cycle pulse for an out-of-range access.
- stall  out  1  — request cannot be accepted this cycle.
- ready  out  1  — clear sequence complete.

## Operation
- FSM states are CLEAR and RUN.
- Reset assertion (asynchronous):
  - state goes to CLEAR and clear_count to 0.
  - read_data, read_valid, addr_error and ready go to 0.
  - The memory array itself is not reset.
- CLEAR state:
  - Each cycle writes `mem[clear_count]`. The value is INIT_VAL0 at INIT_ADDR0, INIT_VAL1 at INIT_ADDR1, and 0 elsewhere.
  - clear_count increments each cycle.
  - After writing index MEM_SIZE-1, the FSM moves to RUN and ready goes to 1.
- RUN is terminal until the next reset.
- Request acceptance: a request is accepted when `ready && (mem_read || mem_write)`.
- `stall = !ready && (mem_read || mem_write)`. It is combinational.
- During CLEAR, requests are ignored: no write and no read_valid. The pipeline must hold the request while stall=1.
- In-range write (address < MEM_SIZE): each lane with byte_enable[k]=1 is updated; lanes with byte_enable[k]=0 are unchanged. byte_enable all-zero means no change.
- In-range read: read_data takes `mem[address]` and read_valid=1 on the next cycle.
- Read and write to the same address in the same cycle (write-first): enabled lanes return write_data, disabled lanes return the old contents.
- Out-of-range access (address ≥ MEM_SIZE):
  - The write is suppressed.
  - If read: read_data=0 and read_valid=1 next cycle.
  - addr_error=1 next cycle for a read, a write, or both.
- Cycle with no accepted read: read_data goes to 0 and read_valid to 0 next cycle.

## Timing
- Read latency is 1 cycle: request at edge N, data valid after edge N+1.
- A write commits at the accepting edge. A read to the same address on the following cycle sees the new data.
- Clear duration is exactly MEM_SIZE cycles from the first rising edge after reset deassertion. ready rises after edge MEM_SIZE.
- Reset asserted mid-CLEAR: the sequence restarts from index 0.
- Reset asserted in RUN: a write not yet committed at an edge is lost. Memory contents are later overwritten by the new CLEAR pass.
- With reset asserted, stall=1 whenever a request is present.
- All outputs except stall are registered.

## Structure
- Package data_memory_pkg contains:
  - the state enum {CLEAR, RUN};
  - a localparam function for lane count (DATA_WIDTH/8);
  - a lane-merge function (old, new, mask) → merged word, used for both the write path and the write-first bypass.
- Sub-module mem_clear_sequencer contains:
  - the FSM and clear_count;
  - outputs clr_we, clr_addr, clr_data and ready.
- The top level arbitrates between the clear port and the request port into a single array write port.

## Test plan
- Release reset with MEM_SIZE=256 and mem_read held at address 1 → stall=1 for 256 cycles, ready rises after edge 256, then read_data=5 with read_valid=1 one cycle later. Address 2 reads 6; address 3 reads 0.
- DATA_WIDTH=32: write 0xAABBCCDD at address 10 with byte_enable=4'b1111, then 0x11223344 with byte_enable=4'b0101 → read of address 10 returns 0xAA22CC44.
- Same-cycle read+write at address 5 (old value 0x00000000), write_data=0xFFFFFFFF, byte_enable=4'b0011 → read_data=0x0000FFFF. The next read of address 5 also returns 0x0000FFFF.
- MEM_SIZE=200, ADDRESS_LINE=8: read address 250 → read_data=0, read_valid=1, addr_error=1. A write to 250 is followed by re-reads of addresses 0–199, which are unchanged.
- Write 0x77 to address 3 in RUN, then assert reset mid-CLEAR at cycle 100 of the next clear pass → clear restarts, ready stays 0 for a further 256 cycles, and address 3 reads 0 afterwards.
- Idle cycle after a read → read_valid=0, read_data=0, stall=0.
